// File: rtl/serial_tx_pkg.sv
// Shared types and defaults for the serial word transmitter.
// Holds the FSM state encoding and the default DATA_W / IDLE_GAP values.
package serial_tx_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_IDLE_GAP = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/serial_tx_testpat.sv
// Ramp word generator for the transmitter test-pattern mode.
// Ports: clk105, reset (sync, active-low), i_inc (advance ramp), o_ramp.
module serial_tx_testpat
    import serial_tx_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk105,
    input  logic              reset,
    input  logic              i_inc,
    output logic [DATA_W-1:0] o_ramp
);

    logic [DATA_W-1:0] r_ramp;

    // Natural wrap from all-ones back to zero.
    always_ff @(posedge clk105) begin
        if (!reset) begin
            r_ramp <= '0;
        end else if (i_inc) begin
            r_ramp <= r_ramp + DATA_W'(1);
        end
    end

    assign o_ramp = r_ramp;

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter: MSB first, cs_n framed, idle gap.
// Ports: clk105, reset (sync, active-low), tx_data/tx_valid/tx_ready
// handshake, sdo, cs_n, busy, frame_done. Defining SERIAL_TX_TESTPAT_EN
// adds input test_mode, which sends a free-running ramp word instead.
module serial_word_tx
    import serial_tx_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int IDLE_GAP = DEF_IDLE_GAP
) (
    input  logic              clk105,
    input  logic              reset,
`ifdef SERIAL_TX_TESTPAT_EN
    input  logic              test_mode,
`endif
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              sdo,
    output logic              cs_n,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(DATA_W);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] w_shreg_nxt;
    logic [CNT_W-1:0]  r_bitcnt;
    logic [CNT_W-1:0]  w_bitcnt_nxt;
    logic [3:0]        r_gapcnt;
    logic [3:0]        w_gapcnt_nxt;
    logic              w_tp_sel;
    logic [DATA_W-1:0] w_load_word;

`ifdef SERIAL_TX_TESTPAT_EN
    logic [DATA_W-1:0] w_ramp;
    logic              r_tp_frame;
    logic              w_ramp_inc;

    assign w_tp_sel    = test_mode;
    assign w_load_word = test_mode ? w_ramp : tx_data;
    // Only frames launched from the ramp advance it; a frame
    // completes even if test_mode drops while it is in flight.
    assign w_ramp_inc  = frame_done & r_tp_frame;

    always_ff @(posedge clk105) begin
        if (!reset) begin
            r_tp_frame <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_tp_frame <= test_mode;
        end
    end

    serial_tx_testpat #(
        .DATA_W (DATA_W)
    ) u_testpat (
        .clk105 (clk105),
        .reset  (reset),
        .i_inc  (w_ramp_inc),
        .o_ramp (w_ramp)
    );
`else
    assign w_tp_sel    = 1'b0;
    assign w_load_word = tx_data;
`endif

    always_ff @(posedge clk105) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_gapcnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_shreg  <= w_shreg_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_gapcnt <= w_gapcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shreg_nxt  = r_shreg;
        w_bitcnt_nxt = r_bitcnt;
        w_gapcnt_nxt = r_gapcnt;
        tx_ready     = 1'b0;
        cs_n         = 1'b1;
        sdo          = 1'b0;
        busy         = 1'b1;
        frame_done   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                busy     = 1'b0;
                tx_ready = ~w_tp_sel;
                if (w_tp_sel || tx_valid) begin
                    w_shreg_nxt  = w_load_word;
                    w_bitcnt_nxt = CNT_W'(DATA_W - 1);
                    w_state_nxt  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                cs_n        = 1'b0;
                sdo         = r_shreg[DATA_W-1];
                w_shreg_nxt = {r_shreg[DATA_W-2:0], 1'b0};
                if (r_bitcnt == '0) begin
                    w_gapcnt_nxt = 4'(IDLE_GAP - 1);
                    w_state_nxt  = ST_GAP;
                end else begin
                    w_bitcnt_nxt = r_bitcnt - CNT_W'(1);
                end
            end
            ST_GAP: begin
                // Gap counter is loaded with IDLE_GAP-1, so that value
                // marks the first gap cycle.
                frame_done = (r_gapcnt == 4'(IDLE_GAP - 1));
                if (r_gapcnt == 4'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gapcnt_nxt = r_gapcnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/serial_word_tx.md
SERIAL_WORD_TX -- requirements
Module: serial_word_tx

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the serial word width in bits; legal range 2..32.
REQ-002 Parameter IDLE_GAP, default 2, SHALL set the number of cs_n-high cycles between frames; legal range 1..15.
REQ-003 clk105  input  1  SHALL be the single clock; all outputs change only on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 tx_data  input  DATA_W  SHALL carry the parallel word to transmit, sampled only on an accepted handshake.
REQ-006 tx_valid  input  1  SHALL indicate tx_data holds a word to transmit.
REQ-007 tx_ready  output  1  SHALL indicate the block can accept a word this cycle.
REQ-008 sdo  output  1  SHALL be the serial data line, MSB first, stable across the following falling edge for receiver sampling.
REQ-009 cs_n  output  1  SHALL be the active-low frame enable, low exactly while data bits are driven.
REQ-010 busy  output  1  SHALL be high in every state except IDLE.
REQ-011 frame_done  output  1  SHALL be a one-cycle pulse marking a completed frame.

Function
REQ-012 The block SHALL implement states IDLE, SHIFT and GAP.
REQ-013 IDLE: tx_ready=1, cs_n=1, sdo=0; on tx_valid=1, the block SHALL capture tx_data into the shift register and go to SHIFT on the next edge.
REQ-014 The block SHALL drive tx_ready=0 in SHIFT and GAP; tx_valid in those states SHALL be ignored and SHALL NOT be queued.
REQ-015 SHIFT: cs_n=0 and sdo=current MSB of the shift register; the block SHALL shift left one bit per cycle for exactly DATA_W cycles, then go to GAP.
REQ-016 Latency: for a word accepted at edge k, bit DATA_W-1 SHALL be on sdo from edge k+1 and bit 0 from edge k+DATA_W.
REQ-017 GAP: cs_n=1 and sdo=0 for exactly IDLE_GAP cycles, then IDLE; frame_done SHALL be 1 in the first GAP cycle only.
REQ-018 The bit counter SHALL be ceil(log2(DATA_W)) bits wide, counting DATA_W-1 down to 0 without wrap; the gap counter SHALL be 4 bits.
REQ-019 Changes on tx_data after acceptance SHALL NOT affect the frame in flight.
REQ-020 Back-to-back frames: with tx_valid held at 1, frame starts SHALL be spaced DATA_W+IDLE_GAP+1 cycles apart.

Reset
REQ-021 With reset=0 at a rising edge, the block SHALL enter IDLE with tx_ready=1, cs_n=1, sdo=0, busy=0, frame_done=0, and shift register, counters (and ramp) at 0.
REQ-022 Reset during SHIFT SHALL abort the frame: cs_n high on the next edge, word discarded, no frame_done.
REQ-023 While reset=0, tx_valid SHALL be ignored.

Configuration
REQ-024 Macro SERIAL_TX_TESTPAT_EN, when defined, SHALL add an input port test_mode (1 bit).
REQ-025 With the macro defined and test_mode=1, the block SHALL hold tx_ready=0, ignore tx_data/tx_valid, and transmit a ramp word back-to-back, starting at 0 after reset and incrementing by 1 per completed frame, wrapping from 2^DATA_W-1 to 0.
REQ-026 If test_mode falls mid-frame, the block SHALL complete the current frame; the ramp SHALL hold its value until the next test_mode frame.
REQ-027 Without the macro, the block SHALL have no test_mode port and no ramp logic.

Structure
REQ-028 Package serial_tx_pkg SHALL hold the state encoding constants and the default values of DATA_W and IDLE_GAP.
REQ-029 The ramp generator SHALL be sub-module serial_tx_testpat, instantiated only under SERIAL_TX_TESTPAT_EN.

Verification
REQ-030 Single word: DATA_W=16, accept 16'hA5C3 -> sdo sequence 1010010111000011 over 16 cycles with cs_n=0, then frame_done for one cycle.
REQ-031 Back-to-back: tx_valid held at 1 with 16'hFFFF then 16'h0001 -> cs_n high exactly 2 cycles between frames, second frame starting 19 cycles after the first.
REQ-032 Data stability: change tx_data to 16'h0000 one cycle after accepting 16'h8001 -> sdo still shows 1000000000000001.
REQ-033 Mid-frame reset: reset=0 after 7 bits of 16'hFFFF -> cs_n=1 and sdo=0 next edge, no frame_done, tx_ready=1 after release.
REQ-034 Ignored valid: pulse tx_valid during SHIFT with 16'h1234 -> no extra frame, no handshake.
REQ-035 Test pattern (macro defined): test_mode=1 for 3 frames after reset -> words 0x0000, 0x0001, 0x0002; DATA_W=4 run of 17 frames -> wrap from 0xF to 0x0.
